// File: rtl/snk_input_pkg.sv
// Shared joystick bit positions, player-word layout and ioctl indices for the SNK input block.
package snk_input_pkg;

  localparam int JOY_R     = 0;
  localparam int JOY_L     = 1;
  localparam int JOY_D     = 2;
  localparam int JOY_U     = 3;
  localparam int JOY_BTN0  = 4;
  localparam int JOY_START = 7;
  localparam int JOY_COIN  = 8;
  localparam int JOY_SVC   = 9;
  localparam int JOY_PAUSE = 10;

  localparam logic [7:0] IOCTL_IDX_DSW  = 8'd254;
  localparam logic [7:0] IOCTL_IDX_GAME = 8'd1;

  typedef struct packed {
    logic [1:0] pad_hi;
    logic       up;
    logic       down;
    logic       right;
    logic       left;
    logic       svc;
    logic [3:0] pad_mid;
    logic [2:0] btn;
    logic       start;
    logic       coin;
  } player_word_t;

  typedef enum logic {
    COIN_IDLE   = 1'b0,
    COIN_ACTIVE = 1'b1
  } coin_state_e;

  localparam player_word_t PLAYER_IDLE = 16'hFFFF;

  // Pass-through fields only; buttons and coin are filled in by the channel logic.
  function automatic player_word_t map_static(input logic [15:0] joy);
    player_word_t w;
    w       = PLAYER_IDLE;
    w.up    = ~joy[JOY_U];
    w.down  = ~joy[JOY_D];
    w.right = ~joy[JOY_R];
    w.left  = ~joy[JOY_L];
    w.svc   = ~joy[JOY_SVC];
    w.start = ~joy[JOY_START];
    return w;
  endfunction

endpackage

// File: rtl/snk_input_chan.sv
// One player channel: direct mapping, coin-pulse stretching and per-button autofire,
// producing a registered active-low player word.
module snk_input_chan
  import snk_input_pkg::*;
#(
  parameter int NBTN        = 3,
  parameter int COIN_FRAMES = 3,
  parameter int AF_FRAMES   = 2
) (
  input  logic            i_clk,
  input  logic            rst_n,
  input  logic [15:0]     joy,
  input  logic [NBTN-1:0] af_en,
  input  logic            tick,
  output logic [15:0]     word
);

  localparam logic [3:0] COIN_LOAD = 4'(COIN_FRAMES);
  localparam logic [3:0] AF_LAST   = 4'(AF_FRAMES - 1);

  coin_state_e     coin_st_q, coin_st_d;
  logic [3:0]      coin_cnt_q, coin_cnt_d;
  logic            coin_prev_q, coin_prev_d;
  logic [NBTN-1:0] btn_prev_q, btn_prev_d;
  logic [3:0]      af_cnt_q, af_cnt_d;
  logic            af_phase_q, af_phase_d;
  player_word_t    word_q, word_d;

  logic            coin_in;
  logic [NBTN-1:0] btn_held;
  logic [NBTN-1:0] af_held;
  logic [NBTN-1:0] af_press;
  logic            unused_joy;

  assign coin_in    = joy[JOY_COIN];
  assign btn_held   = joy[JOY_BTN0 +: NBTN];
  assign af_held    = btn_held & af_en;
  assign af_press   = af_held & ~btn_prev_q;
  // Pause and spare bits are consumed elsewhere or intentionally ignored here.
  assign unused_joy = ^joy;

  // Coin FSM: a rising edge opens a window of at least COIN_FRAMES ticks; held coin extends it.
  always_comb begin
    coin_st_d   = coin_st_q;
    coin_cnt_d  = coin_cnt_q;
    coin_prev_d = coin_in;
    case (coin_st_q)
      COIN_IDLE: begin
        if (coin_in && !coin_prev_q) begin
          coin_st_d  = COIN_ACTIVE;
          coin_cnt_d = COIN_LOAD;
        end else begin
          coin_st_d  = COIN_IDLE;
          coin_cnt_d = 4'd0;
        end
      end
      COIN_ACTIVE: begin
        if (coin_cnt_q == 4'd0) begin
          if (!coin_in) begin
            coin_st_d = COIN_IDLE;
          end else begin
            coin_st_d = COIN_ACTIVE;
          end
        end else if (tick) begin
          coin_cnt_d = coin_cnt_q - 4'd1;
        end else begin
          coin_cnt_d = coin_cnt_q;
        end
      end
      default: begin
        coin_st_d  = COIN_IDLE;
        coin_cnt_d = 4'd0;
      end
    endcase
  end

  // Autofire phase generator; a fresh press forces the fire phase so the first shot is immediate.
  always_comb begin
    af_cnt_d   = af_cnt_q;
    af_phase_d = af_phase_q;
    btn_prev_d = btn_held;
    if (|af_press) begin
      af_cnt_d   = 4'd0;
      af_phase_d = 1'b1;
    end else if (|af_held) begin
      if (tick) begin
        if (af_cnt_q >= AF_LAST) begin
          af_cnt_d   = 4'd0;
          af_phase_d = ~af_phase_q;
        end else begin
          af_cnt_d   = af_cnt_q + 4'd1;
          af_phase_d = af_phase_q;
        end
      end else begin
        af_cnt_d   = af_cnt_q;
        af_phase_d = af_phase_q;
      end
    end else begin
      af_cnt_d   = 4'd0;
      af_phase_d = 1'b1;
    end
  end

  // Output word assembly; button slots beyond NBTN stay at the idle value from map_static.
  always_comb begin
    word_d      = map_static(joy);
    word_d.coin = (coin_st_d == COIN_ACTIVE) ? 1'b0 : 1'b1;
    for (int b = 0; b < NBTN; b++) begin
      if (af_en[b]) begin
        word_d.btn[b] = ~(btn_held[b] & af_phase_d);
      end else begin
        word_d.btn[b] = ~btn_held[b];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_st_q   <= COIN_IDLE;
      coin_cnt_q  <= 4'd0;
      coin_prev_q <= 1'b0;
      btn_prev_q  <= {NBTN{1'b0}};
      af_cnt_q    <= 4'd0;
      af_phase_q  <= 1'b1;
      word_q      <= PLAYER_IDLE;
    end else begin
      coin_st_q   <= coin_st_d;
      coin_cnt_q  <= coin_cnt_d;
      coin_prev_q <= coin_prev_d;
      btn_prev_q  <= btn_prev_d;
      af_cnt_q    <= af_cnt_d;
      af_phase_q  <= af_phase_d;
      word_q      <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/snk_input_ctrl.sv
// Player-input and config-capture block between hps_io and the SNK core: per-player channels,
// frame tick from VBLANK, DIP/game-select capture from ioctl, and merged pause request.
module snk_input_ctrl
  import snk_input_pkg::*;
#(
  parameter int                NPLAYERS    = 2,
  parameter int                NBTN        = 3,
  parameter int                NDSW        = 2,
  parameter int                COIN_FRAMES = 3,
  parameter int                AF_FRAMES   = 2,
  parameter logic [8*NDSW-1:0] DSW_DEFAULT = {NDSW{8'hFF}}
) (
  input  logic                     i_clk,
  input  logic                     RESETn,
  input  logic                     ioctl_wr,
  input  logic [7:0]               ioctl_index,
  input  logic [24:0]              ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  input  logic [16*NPLAYERS-1:0]   joy_in,
  input  logic [NBTN*NPLAYERS-1:0] af_en,
  input  logic                     vblank,
  output logic [16*NPLAYERS-1:0]   player_out,
  output logic [8*NDSW-1:0]        dsw,
  output logic [7:0]               game,
  output logic                     pause_req
);

  logic              vblank_q, vblank_d;
  logic [8*NDSW-1:0] dsw_q, dsw_d;
  logic [7:0]        game_q, game_d;
  logic              pause_q, pause_d;
  logic              tick;
  logic              dsw_wr;
  logic              game_wr;

  assign tick = vblank & ~vblank_q;

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_chan
    snk_input_chan #(
      .NBTN        (NBTN),
      .COIN_FRAMES (COIN_FRAMES),
      .AF_FRAMES   (AF_FRAMES)
    ) u_chan (
      .i_clk (i_clk),
      .rst_n (RESETn),
      .joy   (joy_in[16*p +: 16]),
      .af_en (af_en[NBTN*p +: NBTN]),
      .tick  (tick),
      .word  (player_out[16*p +: 16])
    );
  end

  // ioctl capture, pause merge and VBLANK history.
  always_comb begin
    vblank_d = vblank;
    dsw_d    = dsw_q;
    game_d   = game_q;
    pause_d  = 1'b0;
    dsw_wr   = ioctl_wr && (ioctl_index == IOCTL_IDX_DSW) && (ioctl_addr[24:3] == 22'd0);
    game_wr  = ioctl_wr && (ioctl_index == IOCTL_IDX_GAME) && (ioctl_addr == 25'd0);
    for (int k = 0; k < NDSW; k++) begin
      if (dsw_wr && (ioctl_addr[2:0] == 3'(k))) begin
        dsw_d[8*k +: 8] = ioctl_dout;
      end else begin
        dsw_d[8*k +: 8] = dsw_q[8*k +: 8];
      end
    end
    if (game_wr) begin
      game_d = ioctl_dout;
    end else begin
      game_d = game_q;
    end
    for (int p = 0; p < NPLAYERS; p++) begin
      pause_d = pause_d | joy_in[16*p + JOY_PAUSE];
    end
  end

  // Registers; vblank_q resets high so a VBLANK already asserted at release is not a tick.
  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      vblank_q <= 1'b1;
      dsw_q    <= DSW_DEFAULT;
      game_q   <= 8'd0;
      pause_q  <= 1'b0;
    end else begin
      vblank_q <= vblank_d;
      dsw_q    <= dsw_d;
      game_q   <= game_d;
      pause_q  <= pause_d;
    end
  end

  assign dsw       = dsw_q;
  assign game      = game_q;
  assign pause_req = pause_q;

endmodule

// File: tb/tb_snk_input_ctrl.sv
// Bench for snk_input_ctrl with three players: each task drives one feature, queues the
// expected outputs and compares them one clock later.
module tb_snk_input_ctrl;

  localparam logic [15:0] DSW_DEF = 16'hB7E1;

  logic        i_clk = 1'b0;
  logic        rst_n;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [47:0] joy_in;
  logic [8:0]  af_en;
  logic        vblank;
  logic [47:0] player_out;
  logic [15:0] dsw;
  logic [7:0]  game;
  logic        pause_req;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb_q[$];

  snk_input_ctrl #(
    .NPLAYERS    (3),
    .NBTN        (3),
    .NDSW        (2),
    .COIN_FRAMES (3),
    .AF_FRAMES   (2),
    .DSW_DEFAULT (DSW_DEF)
  ) dut (
    .i_clk       (i_clk),
    .RESETn      (rst_n),
    .ioctl_wr    (ioctl_wr),
    .ioctl_index (ioctl_index),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .joy_in      (joy_in),
    .af_en       (af_en),
    .vblank      (vblank),
    .player_out  (player_out),
    .dsw         (dsw),
    .game        (game),
    .pause_req   (pause_req)
  );

  always #5 i_clk = ~i_clk;

  task automatic clk1();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
    joy_in = 48'd0; af_en = 9'd0; vblank = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++; if (player_out !== 48'hFFFF_FFFF_FFFF) begin errors++; $display("FAIL reset_player_out: got %h expected %h", player_out, 48'hFFFF_FFFF_FFFF); end
    checks++; if (dsw !== DSW_DEF) begin errors++; $display("FAIL reset_dsw: got %h expected %h", dsw, DSW_DEF); end
    checks++; if (game !== 8'h00) begin errors++; $display("FAIL reset_game: got %h expected 00", game); end
    checks++; if (pause_req !== 1'b0) begin errors++; $display("FAIL reset_pause: got %b expected 0", pause_req); end
    rst_n = 1'b1;
    clk1();
    checks++; if (player_out !== 48'hFFFF_FFFF_FFFF) begin errors++; $display("FAIL post_reset_idle: got %h expected %h", player_out, 48'hFFFF_FFFF_FFFF); end
  endtask

  task automatic test_direct();
    logic [15:0] pat [5];
    logic [15:0] exp [5];
    logic [63:0] e;
    joy_in[3] = 1'b1;
    #3;
    checks++; if (player_out[13] !== 1'b1) begin errors++; $display("FAIL up_early: got %b expected 1", player_out[13]); end
    clk1();
    checks++; if (player_out !== 48'hFFFF_FFFF_DFFF) begin errors++; $display("FAIL up_one_clk: got %h expected %h", player_out, 48'hFFFF_FFFF_DFFF); end
    pat = '{16'h0008, 16'h0287, 16'h0070, 16'hFC00, 16'h0000};
    exp = '{16'hDFFF, 16'hE1FD, 16'hFFE3, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 5; i++) begin
      joy_in[15:0] = pat[i];
      sb_q.push_back({16'd0, 32'hFFFF_FFFF, exp[i]});
      clk1();
      e = sb_q.pop_front();
      checks++; if (player_out !== e[47:0]) begin errors++; $display("FAIL direct_map[%0d]: got %h expected %h", i, player_out, e[47:0]); end
    end
  endtask

  task automatic test_coin();
    logic [63:0] e;
    logic c;
    joy_in = 48'd0;
    joy_in[8] = 1'b1;
    sb_q.push_back({16'd0, 48'hFFFF_FFFF_FFFE});
    clk1();
    joy_in[8] = 1'b0;
    e = sb_q.pop_front();
    checks++; if (player_out !== e[47:0]) begin errors++; $display("FAIL coin_tap_start: got %h expected %h", player_out, e[47:0]); end
    // ticks at j = 0, 4, 8; a second tap at j = 5 must not extend the window
    for (int j = 0; j < 16; j++) begin
      vblank = ((j % 4) < 2);
      joy_in[8] = (j == 5);
      c = (j >= 9);
      sb_q.push_back({16'd0, 47'h7FFF_FFFF_FFFF, c});
      clk1();
      e = sb_q.pop_front();
      checks++; if (player_out !== e[47:0]) begin errors++; $display("FAIL coin_tap[%0d]: got %h expected %h", j, player_out, e[47:0]); end
    end
    // coin held for five frames: stays active until released
    for (int j = 0; j < 24; j++) begin
      vblank = ((j % 4) == 1) || ((j % 4) == 2);
      joy_in[8] = (j < 20);
      c = (j >= 20);
      sb_q.push_back({16'd0, 47'h7FFF_FFFF_FFFF, c});
      clk1();
      e = sb_q.pop_front();
      checks++; if (player_out !== e[47:0]) begin errors++; $display("FAIL coin_held[%0d]: got %h expected %h", j, player_out, e[47:0]); end
    end
    joy_in[8] = 1'b0;
  endtask

  task automatic test_autofire();
    logic [63:0] e;
    logic held;
    logic fire;
    logic b0;
    int n;
    af_en = 9'd1;
    // ticks at j = 1, 5, 9, ...; button 0 pressed at j = 2 for 32 cycles
    for (int j = 0; j < 38; j++) begin
      vblank = ((j % 4) == 1) || ((j % 4) == 2);
      held = (j >= 2) && (j < 34);
      joy_in[4] = held;
      n = (j - 1) / 4;
      fire = (((n / 2) % 2) == 0);
      b0 = held ? ~fire : 1'b1;
      sb_q.push_back({16'd0, 32'hFFFF_FFFF, 13'h1FFF, b0, 2'b11});
      clk1();
      e = sb_q.pop_front();
      checks++; if (player_out !== e[47:0]) begin errors++; $display("FAIL autofire[%0d]: got %h expected %h", j, player_out, e[47:0]); end
    end
    af_en = 9'd0;
    for (int j = 0; j < 16; j++) begin
      vblank = ((j % 4) == 1) || ((j % 4) == 2);
      held = (j < 12);
      joy_in[4] = held;
      b0 = ~held;
      sb_q.push_back({16'd0, 32'hFFFF_FFFF, 13'h1FFF, b0, 2'b11});
      clk1();
      e = sb_q.pop_front();
      checks++; if (player_out !== e[47:0]) begin errors++; $display("FAIL af_off[%0d]: got %h expected %h", j, player_out, e[47:0]); end
    end
    joy_in[4] = 1'b0;
    vblank = 1'b0;
  endtask

  task automatic test_dip();
    logic        t_wr  [6];
    logic [7:0]  t_idx [6];
    logic [24:0] t_adr [6];
    logic [7:0]  t_dat [6];
    logic [15:0] t_exp [6];
    logic [63:0] e;
    t_wr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    t_idx = '{8'd254, 8'd254, 8'd254, 8'd254, 8'd253, 8'd254};
    t_adr = '{25'd0, 25'd1, 25'd2, 25'd8, 25'd0, 25'd0};
    t_dat = '{8'h5A, 8'hC3, 8'h11, 8'hEE, 8'h77, 8'h99};
    t_exp = '{16'hB75A, 16'hC35A, 16'hC35A, 16'hC35A, 16'hC35A, 16'hC35A};
    for (int i = 0; i < 6; i++) begin
      ioctl_wr = t_wr[i]; ioctl_index = t_idx[i]; ioctl_addr = t_adr[i]; ioctl_dout = t_dat[i];
      sb_q.push_back({48'd0, t_exp[i]});
      clk1();
      ioctl_wr = 1'b0;
      e = sb_q.pop_front();
      checks++; if (dsw !== e[15:0]) begin errors++; $display("FAIL dip[%0d]: got %h expected %h", i, dsw, e[15:0]); end
    end
    checks++; if (game !== 8'h00) begin errors++; $display("FAIL dip_game_untouched: got %h expected 00", game); end
  endtask

  task automatic test_game();
    logic        t_wr  [5];
    logic [7:0]  t_idx [5];
    logic [24:0] t_adr [5];
    logic [7:0]  t_dat [5];
    logic [7:0]  t_exp [5];
    logic [63:0] e;
    t_wr  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    t_idx = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd1};
    t_adr = '{25'd0, 25'd0, 25'd1, 25'd0, 25'd0};
    t_dat = '{8'h03, 8'h03, 8'h44, 8'h55, 8'hA7};
    t_exp = '{8'h00, 8'h03, 8'h03, 8'h03, 8'hA7};
    for (int i = 0; i < 5; i++) begin
      ioctl_wr = t_wr[i]; ioctl_index = t_idx[i]; ioctl_addr = t_adr[i]; ioctl_dout = t_dat[i];
      sb_q.push_back({56'd0, t_exp[i]});
      clk1();
      ioctl_wr = 1'b0;
      e = sb_q.pop_front();
      checks++; if (game !== e[7:0]) begin errors++; $display("FAIL game[%0d]: got %h expected %h", i, game, e[7:0]); end
    end
    checks++; if (dsw !== 16'hC35A) begin errors++; $display("FAIL game_dsw_untouched: got %h expected C35A", dsw); end
  endtask

  task automatic test_multi();
    logic [47:0] t_joy [4];
    logic [47:0] t_out [4];
    logic        t_pau [4];
    logic [63:0] e;
    t_joy = '{{16'h0400, 16'h0010, 16'h0000}, {16'h0000, 16'h0000, 16'h0400},
              {16'h0000, 16'h0000, 16'h0000}, {16'h0070, 16'h0000, 16'h0000}};
    t_out = '{{16'hFFFF, 16'hFFFB, 16'hFFFF}, {16'hFFFF, 16'hFFFF, 16'hFFFF},
              {16'hFFFF, 16'hFFFF, 16'hFFFF}, {16'hFFE3, 16'hFFFF, 16'hFFFF}};
    t_pau = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      joy_in = t_joy[i];
      sb_q.push_back({15'd0, t_pau[i], t_out[i]});
      clk1();
      e = sb_q.pop_front();
      checks++; if (player_out !== e[47:0]) begin errors++; $display("FAIL multi_out[%0d]: got %h expected %h", i, player_out, e[47:0]); end
      checks++; if (pause_req !== e[48]) begin errors++; $display("FAIL multi_pause[%0d]: got %b expected %b", i, pause_req, e[48]); end
    end
    joy_in = 48'd0;
  endtask

  task automatic test_reset_mid_coin();
    logic [63:0] e;
    logic c;
    joy_in = 48'd0; vblank = 1'b0;
    joy_in[8] = 1'b1;
    clk1();
    checks++; if (player_out !== 48'hFFFF_FFFF_FFFE) begin errors++; $display("FAIL rmid_active: got %h expected %h", player_out, 48'hFFFF_FFFF_FFFE); end
    joy_in[8] = 1'b0;
    vblank = 1'b1;
    clk1();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (player_out !== 48'hFFFF_FFFF_FFFF) begin errors++; $display("FAIL rmid_coin_release: got %h expected %h", player_out, 48'hFFFF_FFFF_FFFF); end
    checks++; if (dsw !== DSW_DEF) begin errors++; $display("FAIL rmid_dsw: got %h expected %h", dsw, DSW_DEF); end
    checks++; if (game !== 8'h00) begin errors++; $display("FAIL rmid_game: got %h expected 00", game); end
    clk1();
    rst_n = 1'b1;
    // vblank still high at release: first real ticks come from rises at j = 8, 12, 16
    for (int j = 0; j < 21; j++) begin
      joy_in[8] = (j == 0);
      vblank = (j < 6) ? 1'b1 : ((j % 4) == 0);
      c = (j >= 17);
      sb_q.push_back({16'd0, 47'h7FFF_FFFF_FFFF, c});
      clk1();
      e = sb_q.pop_front();
      checks++; if (player_out !== e[47:0]) begin errors++; $display("FAIL rmid_coin[%0d]: got %h expected %h", j, player_out, e[47:0]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_direct();
    test_coin();
    test_autofire();
    test_dip();
    test_game();
    test_multi();
    test_reset_mid_coin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
